// File: rtl/pwm_ctrl_pkg.sv
// Shared types and saturating step arithmetic for the PWM duty controller.
// The REPEAT state exists only when PWM_AUTOREPEAT_EN is defined.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
`ifdef PWM_AUTOREPEAT_EN
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
`else
    ST_PRESSED = 2'd1
`endif
  } btn_state_t;

  typedef struct packed {
    logic              sat;
    logic [DUTY_W-1:0] value;
  } clamp_t;

  // Nine-bit intermediate; a carry or borrow out means the result is pinned to a rail.
  function automatic clamp_t clamp_add(input logic [DUTY_W-1:0] a, input logic [DUTY_W-1:0] b);
    clamp_t          r;
    logic [DUTY_W:0] s;
    s       = {1'b0, a} + {1'b0, b};
    r.sat   = s[DUTY_W];
    r.value = s[DUTY_W] ? '1 : s[DUTY_W-1:0];
    return r;
  endfunction

  function automatic clamp_t clamp_sub(input logic [DUTY_W-1:0] a, input logic [DUTY_W-1:0] b);
    clamp_t          r;
    logic [DUTY_W:0] s;
    s       = {1'b0, a} - {1'b0, b};
    r.sat   = s[DUTY_W];
    r.value = s[DUTY_W] ? '0 : s[DUTY_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter for one active-low button.
// level is the debounced button level; press pulses for one cycle on its falling edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [1:0] sync;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      // Any sample that agrees with the current level restarts the stability count.
      if (sync[1] != level) begin
        if (cnt == DEB_LAST) begin
          level <= sync[1];
          press <= ~sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller: debounced inc/dec buttons and a target ramp drive one duty register.
// Define PWM_AUTOREPEAT_EN to build the hold-to-repeat REPEAT state.
module pwm_duty_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int STEP       = 1,
  parameter int DUTY_RST   = 128,
  parameter int RAMP_DIV   = 8,
  parameter int REP_DELAY  = 16,
  parameter int REP_RATE   = 4
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic [DUTY_W-1:0] tgt,
  input  logic              tgt_load,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              sat,
  output logic              ramp_busy,
  output btn_state_t        fsm_state
);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255 || STEP < 1 || STEP > 255 ||
      RAMP_DIV < 1 || RAMP_DIV > 255 || DUTY_RST < 0 || DUTY_RST > 255 ||
      REP_DELAY < 1 || REP_DELAY > 255 || REP_RATE < 1 || REP_RATE > 255) begin : g_param_check
    $error("pwm_duty_ctrl: parameter out of range");
  end

  localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] RST_V    = DUTY_W'(DUTY_RST);
  localparam logic [7:0]        DIV_LAST = 8'(RAMP_DIV - 1);

  logic inc_lvl, inc_press, dec_lvl, dec_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
    .clk   (clkin),
    .rst_n (reset),
    .btn_n (inc),
    .level (inc_lvl),
    .press (inc_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
    .clk   (clkin),
    .rst_n (reset),
    .btn_n (dec),
    .level (dec_lvl),
    .press (dec_press)
  );

  logic held_inc, held_dec, both_held, any_held, held_dir;
  btn_state_t state;
  logic dir_up;
  logic lockout;
`ifdef PWM_AUTOREPEAT_EN
  localparam logic [7:0] DELAY_LAST = 8'(REP_DELAY - 1);
  localparam logic [7:0] RATE_LAST  = 8'(REP_RATE - 1);
  logic [7:0] rep_cnt;
`endif

  logic              btn_step, btn_up;
  clamp_t            btn_res;
  logic [7:0]        div_cnt;
  logic [DUTY_W-1:0] tgt_q, ramp_next;
  logic              ramp_tick;

  assign held_inc  = ~inc_lvl;
  assign held_dec  = ~dec_lvl;
  assign both_held = held_inc & held_dec;
  assign any_held  = held_inc | held_dec;
  assign held_dir  = dir_up ? held_inc : held_dec;
  assign fsm_state = state;

  // A button step is suppressed by a same-cycle tgt_load, by both buttons down, and by lockout.
  always_comb begin
    btn_step = 1'b0;
    btn_up   = 1'b0;
    if (!tgt_load && !both_held && !lockout) begin
      case (state)
        ST_IDLE: begin
          if (inc_press) begin
            btn_step = 1'b1;
            btn_up   = 1'b1;
          end else if (dec_press) begin
            btn_step = 1'b1;
          end
        end
`ifdef PWM_AUTOREPEAT_EN
        ST_PRESSED: begin
          if (held_dir && rep_cnt == DELAY_LAST) begin
            btn_step = 1'b1;
            btn_up   = dir_up;
          end
        end
        ST_REPEAT: begin
          if (held_dir && rep_cnt == RATE_LAST) begin
            btn_step = 1'b1;
            btn_up   = dir_up;
          end
        end
`endif
        default: ;
      endcase
    end
    btn_res = btn_up ? clamp_add(duty, STEP_V) : clamp_sub(duty, STEP_V);
  end

  // Ramp moves STEP toward the target and lands exactly on it for the last step.
  always_comb begin
    if (tgt_q > duty) begin
      ramp_next = ((tgt_q - duty) <= STEP_V) ? tgt_q : duty + STEP_V;
    end else begin
      ramp_next = ((duty - tgt_q) <= STEP_V) ? tgt_q : duty - STEP_V;
    end
  end

  assign ramp_tick = ramp_busy && (div_cnt == DIV_LAST);

  // Lockout holds the FSM in IDLE until every button is released.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      dir_up  <= 1'b0;
      lockout <= 1'b0;
`ifdef PWM_AUTOREPEAT_EN
      rep_cnt <= '0;
`endif
    end else if (tgt_load) begin
      state   <= ST_IDLE;
      lockout <= any_held;
    end else if (both_held) begin
      state   <= ST_IDLE;
      lockout <= 1'b1;
    end else if (lockout) begin
      state <= ST_IDLE;
      if (!any_held) lockout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn_step) begin
            state  <= ST_PRESSED;
            dir_up <= btn_up;
`ifdef PWM_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end
        end
        ST_PRESSED: begin
          if (!held_dir) begin
            state <= ST_IDLE;
`ifdef PWM_AUTOREPEAT_EN
          end else if (btn_step) begin
            state   <= ST_REPEAT;
            rep_cnt <= '0;
          end else begin
            rep_cnt <= rep_cnt + 8'd1;
`endif
          end
        end
`ifdef PWM_AUTOREPEAT_EN
        ST_REPEAT: begin
          if (!held_dir) begin
            state <= ST_IDLE;
          end else if (btn_step) begin
            rep_cnt <= '0;
          end else begin
            rep_cnt <= rep_cnt + 8'd1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Duty register: tgt_load first, then button steps (which abort a ramp), then ramp steps.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      duty      <= RST_V;
      duty_upd  <= 1'b0;
      sat       <= 1'b0;
      ramp_busy <= 1'b0;
      tgt_q     <= RST_V;
      div_cnt   <= '0;
    end else begin
      duty_upd <= 1'b0;
      sat      <= 1'b0;
      if (tgt_load) begin
        tgt_q     <= tgt;
        div_cnt   <= '0;
        ramp_busy <= (tgt != duty);
      end else if (btn_step) begin
        duty      <= btn_res.value;
        duty_upd  <= (btn_res.value != duty);
        sat       <= btn_res.sat;
        ramp_busy <= 1'b0;
      end else if (ramp_tick) begin
        div_cnt  <= '0;
        duty     <= ramp_next;
        duty_upd <= 1'b1;
        if (ramp_next == tgt_q) ramp_busy <= 1'b0;
      end else if (ramp_busy) begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule
